// File: rtl/stack_ctrl.sv
// Evaluation-stack sequencer: takes one opcode per handshake and drives the stack's
// load/push/pop strobes and data input. Also tracks occupancy and runs the 4-step SWAP.
module stack_ctrl #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int DW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op_data,
    output logic             st_load,
    output logic             st_push,
    output logic             st_pop,
    output logic [WIDTH-1:0] st_d,
    input  logic [WIDTH-1:0] st_qtop,
    input  logic [WIDTH-1:0] st_qnext,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [DW-1:0]    depth
);

    typedef enum logic [2:0] {IDLE, EXEC, SW1, SW2, SW3, SW4, RESP} state_t;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_DUP  = 3'd3;
    localparam logic [2:0] OP_SWAP = 3'd4;
    localparam logic [2:0] OP_ADD  = 3'd5;
    localparam logic [2:0] OP_SUB  = 3'd6;

    localparam logic [1:0] E_NONE = 2'd0;
    localparam logic [1:0] E_OVF  = 2'd1;
    localparam logic [1:0] E_UNF  = 2'd2;
    localparam logic [1:0] E_ILL  = 2'd3;

    localparam logic [DW-1:0] FULL = DW'(DEPTH);
    localparam logic [DW-1:0] ONE  = DW'(1);
    localparam logic [DW-1:0] TWO  = DW'(2);

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]  st_d_q, st_d_d;
    logic [DW-1:0]     depth_q, depth_d;
    logic              load_q, load_d, push_q, push_d, pop_q, pop_d;
    logic              done_q, done_d, err_q, err_d;
    logic [1:0]        code_q, code_d;
    logic [1:0]        rej;

    // Strobes and done are decoded from the next state so every output comes straight off a flop.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        depth_d = depth_q;
        load_d  = 1'b0;
        push_d  = 1'b0;
        pop_d   = 1'b0;
        st_d_d  = '0;
        err_d   = 1'b0;
        code_d  = E_NONE;
        rej     = E_NONE;

        case (state_q)
            IDLE: begin
                if (op_valid) begin
                    a_d  = st_qtop;
                    b_d  = st_qnext;
                    op_d = op;
                    case (op)
                        OP_NOP:  rej = E_NONE;
                        OP_PUSH: if (depth_q == FULL) rej = E_OVF;
                        OP_POP:  if (depth_q < ONE) rej = E_UNF;
                        OP_DUP: begin
                            if (depth_q == FULL)     rej = E_OVF;
                            else if (depth_q < ONE)  rej = E_UNF;
                        end
                        OP_SWAP, OP_ADD, OP_SUB: if (depth_q < TWO) rej = E_UNF;
                        default: rej = E_ILL;
                    endcase

                    if (rej != E_NONE) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        code_d  = rej;
                    end else begin
                        case (op)
                            OP_PUSH: begin
                                state_d = EXEC;
                                load_d  = 1'b1;
                                push_d  = 1'b1;
                                st_d_d  = op_data;
                            end
                            OP_POP: begin
                                state_d = EXEC;
                                pop_d   = 1'b1;
                            end
                            OP_DUP: begin
                                state_d = EXEC;
                                push_d  = 1'b1;
                            end
                            OP_SWAP: begin
                                state_d = SW1;
                                pop_d   = 1'b1;
                            end
                            OP_ADD: begin
                                state_d = EXEC;
                                load_d  = 1'b1;
                                pop_d   = 1'b1;
                                st_d_d  = st_qtop + st_qnext;
                            end
                            OP_SUB: begin
                                state_d = EXEC;
                                load_d  = 1'b1;
                                pop_d   = 1'b1;
                                st_d_d  = st_qtop - st_qnext;
                            end
                            default: state_d = RESP;
                        endcase
                    end
                end
            end
            EXEC: begin
                state_d = RESP;
                case (op_q)
                    OP_PUSH, OP_DUP:         depth_d = depth_q + ONE;
                    OP_POP, OP_ADD, OP_SUB:  depth_d = depth_q - ONE;
                    default:                 depth_d = depth_q;
                endcase
            end
            SW1: begin
                state_d = SW2;
                pop_d   = 1'b1;
            end
            // Re-push into the slots the two pops just freed, so a full stack cannot overflow here.
            SW2: begin
                state_d = SW3;
                load_d  = 1'b1;
                push_d  = 1'b1;
                st_d_d  = a_q;
            end
            SW3: begin
                state_d = SW4;
                load_d  = 1'b1;
                push_d  = 1'b1;
                st_d_d  = b_q;
            end
            SW4:     state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        done_d = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= OP_NOP;
            a_q     <= '0;
            b_q     <= '0;
            st_d_q  <= '0;
            depth_q <= '0;
            load_q  <= 1'b0;
            push_q  <= 1'b0;
            pop_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= E_NONE;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            st_d_q  <= st_d_d;
            depth_q <= depth_d;
            load_q  <= load_d;
            push_q  <= push_d;
            pop_q   <= pop_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign op_ready = (state_q == IDLE);
    assign st_load  = load_q;
    assign st_push  = push_q;
    assign st_pop   = pop_q;
    assign st_d     = st_d_q;
    assign done     = done_q;
    assign err      = err_q;
    assign err_code = code_q;
    assign depth    = depth_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: emulates the 8-entry stack, keeps a queue-based model of the
// opcode semantics, and checks strobes, handshake, done/err and depth on every cycle.
module tb_stack_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        op_valid;
    logic        op_ready;
    logic [2:0]  op_in;
    logic [15:0] op_data;
    logic        st_load, st_push, st_pop;
    logic [15:0] st_d;
    logic [15:0] st_qtop, st_qnext;
    logic        done, err;
    logic [1:0]  err_code;
    logic [3:0]  depth;

    always #5 clk = ~clk;

    stack_ctrl #(.WIDTH(16), .DEPTH(8)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
        .op(op_in), .op_data(op_data), .st_load(st_load), .st_push(st_push),
        .st_pop(st_pop), .st_d(st_d), .st_qtop(st_qtop), .st_qnext(st_qnext),
        .done(done), .err(err), .err_code(err_code), .depth(depth)
    );

    // Stack emulator; shares the controller's reset.
    logic [15:0] mem [0:7];
    int          sp;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp <= 0;
        end else if (st_load && st_push) begin
            if (sp < 8) begin mem[3'(sp)] <= st_d; sp <= sp + 1; end
        end else if (st_push) begin
            if (sp >= 1 && sp < 8) begin mem[3'(sp)] <= mem[3'(sp - 1)]; sp <= sp + 1; end
        end else if (st_load && st_pop) begin
            if (sp >= 2) begin mem[3'(sp - 2)] <= st_d; sp <= sp - 1; end
        end else if (st_pop) begin
            if (sp >= 1) sp <= sp - 1;
        end
    end

    always_comb begin
        st_qtop  = (sp >= 1) ? mem[3'(sp - 1)] : 16'h0000;
        st_qnext = (sp >= 2) ? mem[3'(sp - 2)] : 16'h0000;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state: expected contents (index 0 = top) and the timeline of the op in flight.
    logic [15:0] mq [$];
    int          acc_cyc = -100;
    int          lat = 0;
    int          old_d = 0;
    int          new_d = 0;
    logic        exp_err = 1'b0;
    logic [1:0]  exp_code = 2'd0;
    logic [2:0]  exp_str [0:3];
    logic [15:0] exp_dv [0:3];
    logic        last_err;
    logic [1:0]  last_code;
    int          checks = 0;
    int          errors = 0;
    bit          chk_en = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clearTimeline();
        for (int i = 0; i < 4; i++) begin
            exp_str[i] = 3'b000;
            exp_dv[i]  = 16'h0000;
        end
    endtask

    // Applies an accepted opcode to the model; strobe codes are {load,push,pop}.
    task automatic modelAccept(input logic [2:0] o, input logic [15:0] data);
        logic [15:0] a, b, r;
        int sz;
        sz = mq.size();
        old_d = sz;
        exp_err = 1'b0;
        exp_code = 2'd0;
        lat = 1;
        clearTimeline();
        case (o)
            3'd0: lat = 0;
            3'd1: if (sz < 8) begin
                      exp_str[0] = 3'b110; exp_dv[0] = data; mq.push_front(data);
                  end else begin exp_err = 1'b1; exp_code = 2'd1; end
            3'd2: if (sz >= 1) begin
                      exp_str[0] = 3'b001; void'(mq.pop_front());
                  end else begin exp_err = 1'b1; exp_code = 2'd2; end
            3'd3: if (sz == 8) begin exp_err = 1'b1; exp_code = 2'd1; end
                  else if (sz == 0) begin exp_err = 1'b1; exp_code = 2'd2; end
                  else begin a = mq[0]; exp_str[0] = 3'b010; mq.push_front(a); end
            3'd4: if (sz >= 2) begin
                      a = mq[0]; b = mq[1]; lat = 4;
                      exp_str[0] = 3'b001; exp_str[1] = 3'b001;
                      exp_str[2] = 3'b110; exp_dv[2] = a;
                      exp_str[3] = 3'b110; exp_dv[3] = b;
                      mq[0] = b; mq[1] = a;
                  end else begin exp_err = 1'b1; exp_code = 2'd2; end
            3'd5, 3'd6: if (sz >= 2) begin
                      a = mq[0]; b = mq[1];
                      r = (o == 3'd5) ? a + b : a - b;
                      exp_str[0] = 3'b101; exp_dv[0] = r;
                      void'(mq.pop_front()); void'(mq.pop_front()); mq.push_front(r);
                  end else begin exp_err = 1'b1; exp_code = 2'd2; end
            default: begin exp_err = 1'b1; exp_code = 2'd3; end
        endcase
        if (exp_err) lat = 0;
        new_d = mq.size();
        acc_cyc = cyc + 1;
    endtask

    task automatic waitReady();
        int n = 0;
        @(negedge clk);
        while (!op_ready && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!op_ready) begin
            checks++; errors++;
            $display("[TB] FAIL ready_timeout: got op_ready 0 expected 1");
        end
    endtask

    task automatic applyStimulus(input logic [2:0] o, input logic [15:0] data);
        int n = 0;
        bit got = 0;
        waitReady();
        op_valid = 1'b1;
        op_in = o;
        op_data = data;
        modelAccept(o, data);
        @(posedge clk);
        #1 op_valid = 1'b0;
        while (n < 10 && !got) begin
            @(negedge clk);
            if (done) begin
                got = 1;
                last_err = err;
                last_code = err_code;
            end
            n++;
        end
        if (!got) begin
            checks++; errors++;
            $display("[TB] FAIL done_timeout: got no done expected done for op %0d", o);
        end
    endtask

    // Per-cycle compare against the model timeline.
    always @(negedge clk) begin
        int k;
        logic [2:0] es;
        logic [15:0] ed;
        bit busy;
        if (chk_en && reset) begin
            k = cyc - acc_cyc;
            es = 3'b000;
            ed = 16'h0000;
            if (k >= 0 && k <= 3) begin
                es = exp_str[k];
                ed = exp_dv[k];
            end
            busy = (k >= 0 && k <= lat);
            checkOutput("strobes", {29'd0, st_load, st_push, st_pop}, {29'd0, es});
            if (es[2]) checkOutput("st_d", {16'd0, st_d}, {16'd0, ed});
            checkOutput("op_ready", {31'd0, op_ready}, {31'd0, !busy});
            checkOutput("done", {31'd0, done}, {31'd0, (k == lat)});
            checkOutput("depth", {28'd0, depth}, (k >= lat) ? new_d : old_d);
            if (k == lat) begin
                checkOutput("err", {31'd0, err}, {31'd0, exp_err});
                checkOutput("err_code", {30'd0, err_code}, {30'd0, exp_code});
                if (mq.size() >= 1) checkOutput("stack_top", {16'd0, st_qtop}, {16'd0, mq[0]});
                if (mq.size() >= 2) checkOutput("stack_next", {16'd0, st_qnext}, {16'd0, mq[1]});
            end else begin
                checkOutput("err_idle", {31'd0, err}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        op_valid = 1'b0;
        op_in = 3'd0;
        op_data = 16'h0000;
        clearTimeline();
        repeat (2) @(negedge clk);
        checkOutput("rst_load", {31'd0, st_load}, 32'd0);
        checkOutput("rst_push", {31'd0, st_push}, 32'd0);
        checkOutput("rst_pop", {31'd0, st_pop}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_err", {31'd0, err}, 32'd0);
        checkOutput("rst_st_d", {16'd0, st_d}, 32'd0);
        checkOutput("rst_err_code", {30'd0, err_code}, 32'd0);
        checkOutput("rst_depth", {28'd0, depth}, 32'd0);
        reset = 1'b1;
        chk_en = 1;
        #1 checkOutput("ready_after_rst", {31'd0, op_ready}, 32'd1);

        applyStimulus(3'd1, 16'h0011);
        applyStimulus(3'd1, 16'h0022);
        checkOutput("push_top", {16'd0, st_qtop}, 32'h0022);
        checkOutput("push_next", {16'd0, st_qnext}, 32'h0011);
        checkOutput("push_depth", {28'd0, depth}, 32'd2);

        applyStimulus(3'd5, 16'h0000);
        checkOutput("add_top", {16'd0, st_qtop}, 32'h0033);
        checkOutput("add_depth", {28'd0, depth}, 32'd1);
        applyStimulus(3'd1, 16'h0001);
        applyStimulus(3'd6, 16'h0000);
        applyStimulus(3'd1, 16'hFFFF);
        applyStimulus(3'd1, 16'h0002);
        applyStimulus(3'd5, 16'h0000);
        checkOutput("add_wrap_top", {16'd0, st_qtop}, 32'h0001);

        applyStimulus(3'd2, 16'h0000);
        applyStimulus(3'd2, 16'h0000);
        applyStimulus(3'd1, 16'h0005);
        applyStimulus(3'd1, 16'h0011);
        applyStimulus(3'd1, 16'h0022);
        applyStimulus(3'd4, 16'h0000);
        checkOutput("swap_top", {16'd0, st_qtop}, 32'h0011);
        checkOutput("swap_next", {16'd0, st_qnext}, 32'h0022);
        checkOutput("swap_depth", {28'd0, depth}, 32'd3);

        for (int i = 0; i < 3; i++) applyStimulus(3'd2, 16'h0000);
        applyStimulus(3'd2, 16'h0000);
        checkOutput("pop_empty_code", {30'd0, last_code}, 32'd2);
        applyStimulus(3'd1, 16'h0007);
        applyStimulus(3'd5, 16'h0000);
        checkOutput("add_d1_code", {30'd0, last_code}, 32'd2);
        applyStimulus(3'd4, 16'h0000);
        checkOutput("swap_d1_code", {30'd0, last_code}, 32'd2);
        applyStimulus(3'd7, 16'h0000);
        checkOutput("illegal_code", {30'd0, last_code}, 32'd3);
        applyStimulus(3'd0, 16'h0000);
        checkOutput("nop_err", {31'd0, last_err}, 32'd0);
        checkOutput("depth_after_rejects", {28'd0, depth}, 32'd1);

        applyStimulus(3'd3, 16'h0000);
        for (int i = 0; i < 6; i++) applyStimulus(3'd1, 16'h0100 + 16'(i));
        checkOutput("full_depth", {28'd0, depth}, 32'd8);
        applyStimulus(3'd1, 16'h00AA);
        checkOutput("ovf_err", {31'd0, last_err}, 32'd1);
        checkOutput("ovf_code", {30'd0, last_code}, 32'd1);
        checkOutput("ovf_top", {16'd0, st_qtop}, 32'h0105);
        applyStimulus(3'd3, 16'h0000);
        checkOutput("dup_full_code", {30'd0, last_code}, 32'd1);
        applyStimulus(3'd4, 16'h0000);
        checkOutput("swap_full_top", {16'd0, st_qtop}, 32'h0104);
        checkOutput("swap_full_next", {16'd0, st_qnext}, 32'h0105);
        checkOutput("swap_full_depth", {28'd0, depth}, 32'd8);

        // Abort a SWAP while it sits in its second pop cycle.
        waitReady();
        op_valid = 1'b1;
        op_in = 3'd4;
        modelAccept(3'd4, 16'h0000);
        @(posedge clk);
        #1 op_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("sw2_pop", {31'd0, st_pop}, 32'd1);
        reset = 1'b0;
        mq.delete();
        acc_cyc = -100;
        lat = 0;
        old_d = 0;
        new_d = 0;
        exp_err = 1'b0;
        exp_code = 2'd0;
        clearTimeline();
        #1;
        checkOutput("abort_strobes", {29'd0, st_load, st_push, st_pop}, 32'd0);
        checkOutput("abort_depth", {28'd0, depth}, 32'd0);
        checkOutput("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1 checkOutput("abort_ready", {31'd0, op_ready}, 32'd1);
        applyStimulus(3'd1, 16'h1234);
        checkOutput("post_abort_top", {16'd0, st_qtop}, 32'h1234);
        checkOutput("post_abort_depth", {28'd0, depth}, 32'd1);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
